pio_in_edge_irq: RTL and testbench

- Parametrised Avalon-MM input PIO slave; next generation of the single-bit, read-only status input used for system-halt style signals.
- Adds WIDTH-bit inputs, a configurable synchroniser, per-bit edge capture with write-1-to-clear, an interrupt mask and a level IRQ output.
- Sits between asynchronous board or fabric status lines and the Nios II data master. Its IRQ goes to the processor interrupt controller.

---
 rtl/pio_pkg.sv | 22 ++
 rtl/pio_in_edge_irq_if.sv | 31 +++
 rtl/pio_sync_edge.sv | 47 ++++
 rtl/pio_in_edge_irq.sv | 103 ++++++++++
 tb/tb_pio_in_edge_irq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pio_pkg : shared register map and edge-type encodings for the input PIO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pio_pkg;

  localparam int PIO_BUS_W = 32;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_RSVD    = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/pio_in_edge_irq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pio_in_edge_irq_if : Avalon-MM slave bus bundle for the input PIO       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pio_in_edge_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

endinterface
`default_nettype wire

// File: rtl/pio_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pio_sync_edge : one-bit synchroniser, delay flop and edge-type select   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_rise;
  logic                   w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = o_sync & ~r_dly;
  assign w_fall = ~o_sync & r_dly;

  if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
    assign o_edge = w_fall;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
    assign o_edge = w_rise | w_fall;
  end else begin : g_edge_rise
    assign o_edge = w_rise;
  end

endmodule
`default_nettype wire

// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pio_in_edge_irq : Avalon-MM input PIO with edge capture and level IRQ   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter int          EDGE_TYPE      = EDGE_RISING,
  parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_in_edge_irq_if.slave avs,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int                 c_ARM_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [c_ARM_W-1:0] c_ARM_MAX = c_ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     w_edge;
  logic [WIDTH-1:0]     w_set;
  logic [WIDTH-1:0]     w_clr;
  logic [WIDTH-1:0]     w_edgecap_nxt;
  logic [PIO_BUS_W-1:0] w_rdata_nxt;
  logic                 w_wr;
  logic                 w_armed;
  logic                 w_unused_wdata;

  logic [c_ARM_W-1:0]   r_arm_cnt;
  logic [WIDTH-1:0]     r_irqmask;
  logic [WIDTH-1:0]     r_edgecap;
  logic [PIO_BUS_W-1:0] r_readdata;
  logic                 r_irq;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (in_port[gi]),
      .o_sync  (w_sync[gi]),
      .o_edge  (w_edge[gi])
    );
  end

  // Hold off capture until the synchroniser and delay flop hold real samples,
  // so a line already high at reset release does not look like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed        = (r_arm_cnt == c_ARM_MAX);
  assign w_wr           = avs.chipselect & ~avs.write_n;
  assign w_unused_wdata = ^avs.writedata;

  assign w_clr = (w_wr && (avs.address == PIO_ADDR_EDGECAP)) ? avs.writedata[WIDTH-1:0] : '0;
  assign w_set = w_edge & {WIDTH{w_armed}};

  // A fresh edge beats a simultaneous clear so no event is ever lost.
  assign w_edgecap_nxt = (r_edgecap & ~w_clr) | w_set;

  always_comb begin
    w_rdata_nxt = '0;
    case (avs.address)
      PIO_ADDR_DATA:    w_rdata_nxt[WIDTH-1:0] = w_sync;
      PIO_ADDR_IRQMASK: w_rdata_nxt[WIDTH-1:0] = r_irqmask;
      PIO_ADDR_EDGECAP: w_rdata_nxt[WIDTH-1:0] = r_edgecap;
      default:          w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= IRQ_MASK_RESET[WIDTH-1:0];
      r_edgecap  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (avs.address == PIO_ADDR_IRQMASK)) begin
        r_irqmask <= avs.writedata[WIDTH-1:0];
      end
      r_edgecap  <= w_edgecap_nxt;
      r_readdata <= w_rdata_nxt;
      r_irq      <= |(r_edgecap & r_irqmask);
    end
  end

  assign avs.readdata = r_readdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pio_in_edge_irq : rising-edge and any-edge instances on one stimulus |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pio_in_edge_irq;
  import pio_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    logic [W-1:0] in;
    logic [1:0]   addr;
    logic         cs;
    logic         wr_n;
    logic [31:0]  wdata;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in_port = '0;
  logic [1:0]   addr    = '0;
  logic         cs      = 1'b0;
  logic         wr_n    = 1'b1;
  logic [31:0]  wdata   = '0;
  logic         irq_r;
  logic         irq_a;

  int nvec = 0;
  int nerr = 0;

  pio_in_edge_irq_if bus_r ();
  pio_in_edge_irq_if bus_a ();

  assign bus_r.address    = addr;
  assign bus_r.chipselect = cs;
  assign bus_r.write_n    = wr_n;
  assign bus_r.writedata  = wdata;
  assign bus_a.address    = addr;
  assign bus_a.chipselect = cs;
  assign bus_a.write_n    = wr_n;
  assign bus_a.writedata  = wdata;

  pio_in_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISING), .IRQ_MASK_RESET(32'h0)
  ) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .avs(bus_r.slave), .in_port(in_port), .irq(irq_r)
  );

  pio_in_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY), .IRQ_MASK_RESET(32'h0)
  ) u_dut_any (
    .clk(clk), .reset_n(reset_n), .avs(bus_a.slave), .in_port(in_port), .irq(irq_a)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = rising-edge instance, 1 = any-edge instance
  logic [W-1:0]  hist[$];
  int            m_edges;
  logic [W-1:0]  m_cap[2];
  logic [W-1:0]  m_mask[2];
  logic [31:0]   m_rd[2];
  logic          m_irq[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 1; i++) hist.push_back('0);
    m_edges = 0;
    for (int k = 0; k < 2; k++) begin
      m_cap[k]  = '0;
      m_mask[k] = '0;
      m_rd[k]   = '0;
      m_irq[k]  = 1'b0;
    end
  endtask

  // One rising clock edge: s is in_port as sampled S edges back, d one further.
  task automatic model_clock();
    logic [W-1:0] s, d, e, clr;
    bit wr;
    s  = hist[hist.size() - S];
    d  = hist[hist.size() - S - 1];
    wr = cs && !wr_n;
    clr = (wr && addr == 2'd3) ? wdata[W-1:0] : '0;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? (s & ~d) : (s ^ d);
      if (m_edges < S + 1) e = '0;
      case (addr)
        2'd0:    m_rd[k] = 32'(s);
        2'd1:    m_rd[k] = 32'h0;
        2'd2:    m_rd[k] = 32'(m_mask[k]);
        default: m_rd[k] = 32'(m_cap[k]);
      endcase
      m_irq[k] = |(m_cap[k] & m_mask[k]);
      m_cap[k] = (m_cap[k] & ~clr) | e;
      if (wr && addr == 2'd2) m_mask[k] = wdata[W-1:0];
    end
    hist.push_back(in_port);
    void'(hist.pop_front());
    m_edges++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clock();
    @(negedge clk);
    chk("rd_rise",  bus_r.readdata,   m_rd[0]);
    chk("irq_rise", {31'b0, irq_r},  {31'b0, m_irq[0]});
    chk("rd_any",   bus_a.readdata,   m_rd[1]);
    chk("irq_any",  {31'b0, irq_a},  {31'b0, m_irq[1]});
  endtask

  // Called at a negedge: drops reset mid low-phase and checks the async clear.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_rise",  bus_r.readdata,  32'h0);
    chk("rst_irq_rise", {31'b0, irq_r}, 32'h0);
    chk("rst_rd_any",   bus_a.readdata,  32'h0);
    chk("rst_irq_any",  {31'b0, irq_a}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] dv);
    addr = a; cs = 1'b1; wr_n = 1'b0; wdata = dv;
    tick();
    cs = 1'b0; wr_n = 1'b1; wdata = '0;
  endtask

  function automatic vec_t mk(input logic [W-1:0] in, input logic [1:0] a, input logic c,
                              input logic wn, input logic [31:0] wd,
                              input logic [31:0] rd, input logic iq);
    vec_t v;
    v.in = in; v.addr = a; v.cs = c; v.wr_n = wn; v.wdata = wd;
    v.exp_rd = rd; v.exp_irq = iq;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    // Rising-edge instance, starting armed with in_port=0, mask=0, capture=0
    tbl[0]  = mk(8'h00, 2'd2, 1'b1, 1'b0, 32'hFFFF_FF5A, 32'h00, 1'b0);
    tbl[1]  = mk(8'h00, 2'd2, 1'b0, 1'b1, 32'h0,         32'h5A, 1'b0);
    tbl[2]  = mk(8'h00, 2'd1, 1'b1, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[3]  = mk(8'h00, 2'd0, 1'b1, 1'b0, 32'hFF,        32'h00, 1'b0);
    tbl[4]  = mk(8'h00, 2'd2, 1'b0, 1'b1, 32'h0,         32'h5A, 1'b0);
    tbl[5]  = mk(8'h00, 2'd2, 1'b1, 1'b0, 32'h1,         32'h5A, 1'b0);
    tbl[6]  = mk(8'h01, 2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[7]  = mk(8'h01, 2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[8]  = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[9]  = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h01, 1'b1);
    tbl[10] = mk(8'h01, 2'd3, 1'b1, 1'b0, 32'h1,         32'h01, 1'b1);
    tbl[11] = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[12] = mk(8'h00, 2'd0, 1'b0, 1'b1, 32'h0,         32'h01, 1'b0);
    tbl[13] = mk(8'h00, 2'd0, 1'b0, 1'b1, 32'h0,         32'h01, 1'b0);
    tbl[14] = mk(8'h00, 2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[15] = mk(8'h00, 2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[16] = mk(8'h01, 2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[17] = mk(8'h01, 2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);
    tbl[18] = mk(8'h01, 2'd3, 1'b1, 1'b0, 32'h1,         32'h00, 1'b0);
    tbl[19] = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h01, 1'b1);
    tbl[20] = mk(8'h01, 2'd2, 1'b1, 1'b0, 32'h0,         32'h01, 1'b1);
    tbl[21] = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h01, 1'b0);
    tbl[22] = mk(8'h01, 2'd3, 1'b1, 1'b0, 32'hFF,        32'h01, 1'b0);
    tbl[23] = mk(8'h01, 2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0);

    model_reset();

    // Reset released with every line already high: nothing may be captured
    in_port = 8'hFF;
    @(negedge clk);
    apply_reset();
    addr = 2'd3;
    repeat (10) tick();
    chk("hi_at_reset_cap_rise", bus_r.readdata, 32'h0);
    chk("hi_at_reset_cap_any",  bus_a.readdata, 32'h0);
    chk("hi_at_reset_irq_rise", {31'b0, irq_r}, 32'h0);
    addr = 2'd0;
    tick();
    chk("hi_at_reset_data", bus_r.readdata, 32'h0000_00FF);

    in_port = 8'h00;
    repeat (4) tick();

    for (int i = 0; i < 24; i++) begin
      in_port = tbl[i].in; addr = tbl[i].addr; cs = tbl[i].cs;
      wr_n = tbl[i].wr_n; wdata = tbl[i].wdata;
      tick();
      chk($sformatf("tbl%0d_rd", i),  bus_r.readdata,          tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'b0, irq_r},         {31'b0, tbl[i].exp_irq});
    end
    cs = 1'b0; wr_n = 1'b1; wdata = '0;

    // Falling edge on bit 3 with mask 0, then unmask
    in_port = 8'h09; addr = 2'd3;
    repeat (4) tick();
    bus_wr(2'd3, 32'hFF);
    in_port = 8'h01; addr = 2'd3;
    repeat (5) tick();
    chk("fall3_cap_any",  bus_a.readdata, 32'h08);
    chk("fall3_cap_rise", bus_r.readdata, 32'h00);
    chk("fall3_irq_any",  {31'b0, irq_a}, 32'h0);
    bus_wr(2'd2, 32'h08);
    addr = 2'd3;
    tick();
    chk("unmask_irq_any",  {31'b0, irq_a}, 32'h1);
    chk("unmask_irq_rise", {31'b0, irq_r}, 32'h0);

    // Capture 0xC0, then reset in the middle of it
    bus_wr(2'd3, 32'hFF);
    bus_wr(2'd2, 32'hC0);
    in_port = 8'hC1; addr = 2'd3;
    repeat (5) tick();
    chk("c0_cap_rise", bus_r.readdata, 32'hC0);
    chk("c0_irq_rise", {31'b0, irq_r}, 32'h1);
    apply_reset();
    addr = 2'd3;
    repeat (10) tick();
    chk("rearm_cap_rise", bus_r.readdata, 32'h0);
    chk("rearm_cap_any",  bus_a.readdata, 32'h0);
    addr = 2'd0;
    tick();
    chk("rearm_data", bus_r.readdata, 32'h0000_00C1);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) in_port = W'($urandom);
      addr = 2'($urandom_range(3));
      wdata = $urandom;
      case ($urandom_range(7))
        0, 1:    begin cs = 1'b1; wr_n = 1'b0; end
        2:       begin cs = 1'b0; wr_n = 1'b0; end
        3:       begin cs = 1'b1; wr_n = 1'b1; end
        default: begin cs = 1'b0; wr_n = 1'b1; end
      endcase
      tick();
      if (n == 300) begin
        cs = 1'b0; wr_n = 1'b1;
        apply_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
